bconv_window_engine: RTL and testbench
======================================

Name: bconv_window_engine

Overview:
- Sequential binary-convolution engine for the BNN datapath.
- Captures one binarised feature map and N_CH binary kernels, then slides a K_H x K_W window over the map in row-major order.
- For each window position it emits one XNOR-popcount per channel (or its thresholded sign bit) on a valid/ready stream.
- Replaces the single-kernel free-running convolver with a start/busy/done-controlled, back-pressurable, multi-channel block.

Parameters:
- IN_H, 28, input map height
- IN_W, 28, input map width
- K_H, 3, kernel height
- K_W, 3, kernel width
- N_CH, 1, number of kernels / output channels
- SIGN_MODE, 0, 0 = emit popcount; 1 = emit (popcount >= THRESH) in the field LSB
- THRESH, 5, sign threshold; used only when SIGN_MODE=1
- Derived (localparam, not overridable):
  - OUT_H = IN_H-K_H+1
  - OUT_W = IN_W-K_W+1
  - PC_W = $clog2(K_H*K_W+1)

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- start  in  1  begin a layer pass; sampled only in IDLE
- layer_i  in  IN_H*IN_W  flattened map; pixel (r,c) = bit r*IN_W+c
- kernel_i  in  N_CH*K_H*K_W  kernels; channel n tap (kr,kc) = bit n*K_H*K_W + kr*K_W + kc
- busy  out  1  high from the cycle after start is accepted until done
- out_valid  out  1  out_data/out_row/out_col hold a result
- out_ready  in  1  consumer accepts a result when out_valid && out_ready
- out_row  out  $clog2(OUT_H)  row of the current result
- out_col  out  $clog2(OUT_W)  column of the current result
- out_data  out  N_CH*PC_W  channel n in bits [n*PC_W +: PC_W]
- done  out  1  single-cycle pulse after the last result is accepted

Behaviour:
- Reset:
  - State returns to IDLE; busy=0, out_valid=0, done=0.
  - out_row, out_col and out_data are all 0.
  - Captured image and kernel registers are cleared.
- FSM states: IDLE, LOAD, RUN, DRAIN, FIN.
  - IDLE: start=1 -> LOAD. start is ignored in every other state.
  - LOAD (1 cycle): register layer_i and kernel_i; clear the position counters; -> RUN. Inputs may change freely after LOAD.
  - RUN: compute the window at position (pr,pc) and load it into the output register whenever that register is empty or being accepted this cycle.
    - pc increments, wrapping to 0 at OUT_W-1 with pr++.
    - After loading (OUT_H-1, OUT_W-1) -> DRAIN.
  - DRAIN: hold until the final result is accepted -> FIN.
  - FIN (1 cycle): done=1, busy=0 -> IDLE.
- Latency and throughput:
  - start high at edge E0 -> LOAD after E0.
  - First out_valid asserts after E2.
  - With out_ready held high, one result per cycle.
  - done asserts OUT_H*OUT_W cycles after the first out_valid.
- Backpressure: while out_valid && !out_ready, out_data, out_row and out_col are held stable and the position counters do not advance. No result is dropped or duplicated.
- Window arithmetic:
  - Window tap (kr,kc) = pixel (pr+kr, pc+kc).
  - match = ~(pixel ^ tap).
  - popcount = sum of matches over K_H*K_W taps, range 0..K_H*K_W, unsigned, PC_W bits. No saturation is needed.
- SIGN_MODE=1: field = {(PC_W-1)'b0, popcount >= THRESH}.
- Degenerate case OUT_H=OUT_W=1 (K equals the image size): exactly one result, then done.
- Reset mid-operation: abort immediately to IDLE with reset values. A subsequent start performs a fresh pass.
- start held high through FIN:
  - A new pass begins on the cycle IDLE is re-entered.
  - done and start in the same cycle is legal.
- No combinational path from out_ready to out_valid or out_data.

Decomposition:
- Package bnn_pkg:
  - popcount function (generic width)
  - state enum bconv_state_t
  - helper constant function for PC_W
- Sub-module bconv_xnor_popcount:
  - Parameters TAPS and PC_W.
  - Combinational XNOR + popcount of one window against one kernel.
  - Instantiated N_CH times via generate.
- The window mux, FSM, counters and output register remain in bconv_window_engine.

Test Plan:
- Defaults; image all 1s, kernel all 1s; out_ready=1 -> 676 results, every out_data=9, row/col sweep (0,0)..(25,25), done exactly once.
- IN 5x5, K 3x3, N_CH=2; checkerboard image; kernel0 = checkerboard phase 0, kernel1 = its inverse -> at (0,0) ch0=9, ch1=0; at (0,1) ch0=0, ch1=9; pattern alternates; 9 results.
- Backpressure: out_ready pattern 1,0,0,1 repeating -> out_data stable while stalled; sequence identical to the out_ready=1 run; done delayed accordingly.
- SIGN_MODE=1, THRESH=5; image all 0s, kernel with 4 zeros and 5 ones -> popcount 4 -> every field = 0. With 5 zeros -> every field = 1.
- Assert rst for 1 cycle at the 100th result -> busy=0 and out_valid=0 immediately; no done. Restart -> full 676-result pass.
- Pulse start while busy -> ignored; result count unchanged; exactly one done pulse.

Source files
------------

// File: rtl/bnn_pkg.sv
// Shared types and helpers for the binarised-network datapath blocks.
package bnn_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_RUN,
        ST_DRAIN,
        ST_FIN
    } bconv_state_t;

    // Widest vector popcount() accepts; narrower callers zero-extend.
    localparam int POP_MAX_W = 1024;

    function automatic int unsigned popcount(input logic [POP_MAX_W-1:0] v);
        int unsigned cnt;
        cnt = 0;
        for (int i = 0; i < POP_MAX_W; i++) begin
            cnt += 32'(v[i]);
        end
        return cnt;
    endfunction

    // Bits needed to hold a count in 0..taps.
    function automatic int pc_width(input int taps);
        return $clog2(taps + 1);
    endfunction

endpackage

// File: rtl/bconv_xnor_popcount.sv
// XNOR of one window against one kernel, reduced to a match count.
module bconv_xnor_popcount
    import bnn_pkg::*;
#(
    parameter int TAPS = 9,
    parameter int PC_W = 4
) (
    input  logic [TAPS-1:0] window,
    input  logic [TAPS-1:0] kernel,
    output logic [PC_W-1:0] count
);

    logic [POP_MAX_W-1:0] match_ext;

    always_comb begin
        match_ext = '0;
        match_ext[TAPS-1:0] = ~(window ^ kernel);
    end

    assign count = PC_W'(popcount(match_ext));

endmodule

// File: rtl/bconv_window_engine.sv
// Multi-channel binary convolution: captures a map and kernels, then streams
// one XNOR-popcount word per window position in row-major order.
module bconv_window_engine
    import bnn_pkg::*;
#(
    parameter int IN_H      = 28,
    parameter int IN_W      = 28,
    parameter int K_H       = 3,
    parameter int K_W       = 3,
    parameter int N_CH      = 1,
    parameter int SIGN_MODE = 0,
    parameter int THRESH    = 5,
    localparam int OUT_H    = IN_H - K_H + 1,
    localparam int OUT_W    = IN_W - K_W + 1,
    localparam int TAPS     = K_H * K_W,
    localparam int PC_W     = pc_width(K_H * K_W),
    localparam int ROW_W    = (OUT_H > 1) ? $clog2(OUT_H) : 1,
    localparam int COL_W    = (OUT_W > 1) ? $clog2(OUT_W) : 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic [IN_H*IN_W-1:0]   layer_i,
    input  logic [N_CH*TAPS-1:0]   kernel_i,
    output logic                   busy,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [ROW_W-1:0]       out_row,
    output logic [COL_W-1:0]       out_col,
    output logic [N_CH*PC_W-1:0]   out_data,
    output logic                   done
);

    localparam int IDX_W = (IN_H * IN_W > 1) ? $clog2(IN_H * IN_W) : 1;
    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(OUT_H - 1);
    localparam logic [COL_W-1:0] COL_LAST = COL_W'(OUT_W - 1);

    bconv_state_t          state;
    logic [IN_H*IN_W-1:0]  img;
    logic [N_CH*TAPS-1:0]  ker;
    logic [ROW_W-1:0]      pr;
    logic [COL_W-1:0]      pc;
    logic [IDX_W-1:0]      base;
    logic [TAPS-1:0]       window;
    logic [PC_W-1:0]       pop [N_CH];
    logic [N_CH*PC_W-1:0]  win_data;
    logic                  last_pos;

    // Pixel index of the window's top-left tap; every tap is a fixed offset from it.
    assign base = IDX_W'(pr) * IDX_W'(IN_W) + IDX_W'(pc);

    for (genvar kr = 0; kr < K_H; kr++) begin : g_row
        for (genvar kc = 0; kc < K_W; kc++) begin : g_col
            assign window[kr*K_W + kc] = img[base + IDX_W'(kr*IN_W + kc)];
        end
    end

    for (genvar n = 0; n < N_CH; n++) begin : g_ch
        bconv_xnor_popcount #(
            .TAPS (TAPS),
            .PC_W (PC_W)
        ) u_xnor_popcount (
            .window (window),
            .kernel (ker[n*TAPS +: TAPS]),
            .count  (pop[n])
        );

        if (SIGN_MODE != 0) begin : g_sign
            assign win_data[n*PC_W +: PC_W] = PC_W'(int'(pop[n]) >= THRESH);
        end else begin : g_count
            assign win_data[n*PC_W +: PC_W] = pop[n];
        end
    end

    assign last_pos = (pr == ROW_LAST) && (pc == COL_LAST);

    // Output stream: a word transfers on a rising edge where out_valid && out_ready;
    // the register refills only when empty or being accepted, so out_ready never
    // reaches out_valid/out_data combinationally and held words stay stable.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_IDLE;
            busy      <= 1'b0;
            out_valid <= 1'b0;
            done      <= 1'b0;
            out_row   <= '0;
            out_col   <= '0;
            out_data  <= '0;
            img       <= '0;
            ker       <= '0;
            pr        <= '0;
            pc        <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        state <= ST_LOAD;
                        busy  <= 1'b1;
                    end
                end
                ST_LOAD: begin
                    img   <= layer_i;
                    ker   <= kernel_i;
                    pr    <= '0;
                    pc    <= '0;
                    state <= ST_RUN;
                end
                ST_RUN: begin
                    if (!out_valid || out_ready) begin
                        out_valid <= 1'b1;
                        out_data  <= win_data;
                        out_row   <= pr;
                        out_col   <= pc;
                        if (last_pos) begin
                            state <= ST_DRAIN;
                        end else if (pc == COL_LAST) begin
                            pc <= '0;
                            pr <= pr + 1'b1;
                        end else begin
                            pc <= pc + 1'b1;
                        end
                    end
                end
                ST_DRAIN: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        busy      <= 1'b0;
                        done      <= 1'b1;
                        state     <= ST_FIN;
                    end
                end
                ST_FIN: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bconv_window_engine.sv
// Bench for bconv_window_engine: four configurations checked against a
// window-level reference model under random and patterned back-pressure.
module tb_bconv_window_engine;

    logic clk;
    logic rst;

    int total;
    int bad;

    logic          start_v [4];
    logic          ready_v [4];
    logic [1023:0] layer_v [4];
    logic [63:0]   kern_v  [4];
    logic          busy_v  [4];
    logic          valid_v [4];
    logic          done_v  [4];
    logic [15:0]   data_v  [4];
    logic [7:0]    row_v   [4];
    logic [7:0]    col_v   [4];

    logic [3:0] d0_data; logic [4:0] d0_row; logic [4:0] d0_col;
    logic [7:0] d1_data; logic [1:0] d1_row; logic [1:0] d1_col;
    logic [7:0] d2_data; logic [1:0] d2_row; logic [1:0] d2_col;
    logic [3:0] d3_data; logic [0:0] d3_row; logic [0:0] d3_col;

    assign data_v[0] = 16'(d0_data); assign row_v[0] = 8'(d0_row); assign col_v[0] = 8'(d0_col);
    assign data_v[1] = 16'(d1_data); assign row_v[1] = 8'(d1_row); assign col_v[1] = 8'(d1_col);
    assign data_v[2] = 16'(d2_data); assign row_v[2] = 8'(d2_row); assign col_v[2] = 8'(d2_col);
    assign data_v[3] = 16'(d3_data); assign row_v[3] = 8'(d3_row); assign col_v[3] = 8'(d3_col);

    // 28x28, 3x3, one channel, popcount output
    bconv_window_engine u_dut0 (
        .clk(clk), .rst(rst), .start(start_v[0]),
        .layer_i(layer_v[0][783:0]), .kernel_i(kern_v[0][8:0]),
        .busy(busy_v[0]), .out_valid(valid_v[0]), .out_ready(ready_v[0]),
        .out_row(d0_row), .out_col(d0_col), .out_data(d0_data), .done(done_v[0])
    );

    // 5x5, 3x3, two channels, popcount output
    bconv_window_engine #(.IN_H(5), .IN_W(5), .K_H(3), .K_W(3), .N_CH(2)) u_dut1 (
        .clk(clk), .rst(rst), .start(start_v[1]),
        .layer_i(layer_v[1][24:0]), .kernel_i(kern_v[1][17:0]),
        .busy(busy_v[1]), .out_valid(valid_v[1]), .out_ready(ready_v[1]),
        .out_row(d1_row), .out_col(d1_col), .out_data(d1_data), .done(done_v[1])
    );

    // 5x5, 3x3, two channels, thresholded sign output
    bconv_window_engine #(.IN_H(5), .IN_W(5), .K_H(3), .K_W(3), .N_CH(2),
                          .SIGN_MODE(1), .THRESH(5)) u_dut2 (
        .clk(clk), .rst(rst), .start(start_v[2]),
        .layer_i(layer_v[2][24:0]), .kernel_i(kern_v[2][17:0]),
        .busy(busy_v[2]), .out_valid(valid_v[2]), .out_ready(ready_v[2]),
        .out_row(d2_row), .out_col(d2_col), .out_data(d2_data), .done(done_v[2])
    );

    // kernel the size of the image: a single output position
    bconv_window_engine #(.IN_H(3), .IN_W(3), .K_H(3), .K_W(3)) u_dut3 (
        .clk(clk), .rst(rst), .start(start_v[3]),
        .layer_i(layer_v[3][8:0]), .kernel_i(kern_v[3][8:0]),
        .busy(busy_v[3]), .out_valid(valid_v[3]), .out_ready(ready_v[3]),
        .out_row(d3_row), .out_col(d3_col), .out_data(d3_data), .done(done_v[3])
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- checking ----------------
    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [1023:0] rand_vec();
        logic [1023:0] v;
        for (int k = 0; k < 32; k++) v[k*32 +: 32] = $urandom;
        return v;
    endfunction

    // Reference: count agreeing pixel/tap pairs per channel, straight from the window definition.
    function automatic logic [31:0] ref_word(input logic [1023:0] img, input logic [63:0] ker,
                                            input int iw, input int kh, input int kw,
                                            input int nch, input int sm, input int th,
                                            input int pr, input int pc);
        logic [31:0] w;
        int pcw;
        int cnt;
        int f;
        w = 0;
        pcw = $clog2(kh * kw + 1);
        for (int ch = 0; ch < nch; ch++) begin
            cnt = 0;
            for (int kr = 0; kr < kh; kr++)
                for (int kc = 0; kc < kw; kc++)
                    if (img[(pr + kr) * iw + pc + kc] == ker[ch * kh * kw + kr * kw + kc]) cnt++;
            f = (sm != 0) ? ((cnt >= th) ? 1 : 0) : cnt;
            w = w | (32'(f) << (ch * pcw));
        end
        return w;
    endfunction

    // ---------------- driver ----------------
    // rmode: 0 ready always high, 1 ready pattern 1,0,0,1, 2 random ready
    task automatic run_pass(input int i, input int ih, input int iw, input int kh, input int kw,
                            input int nch, input int sm, input int th, input int rmode,
                            input int abort_at, input bit poke_start);
        int oh, ow, n, acc, dones, cyc, rc;
        bit fin, aborted, stalled, r;
        logic [15:0] held_d;
        logic [7:0] held_r, held_c;
        logic [1023:0] img;
        logic [63:0] ker;
        oh = ih - kh + 1; ow = iw - kw + 1; n = oh * ow;
        acc = 0; dones = 0; cyc = 0; rc = 0;
        fin = 0; aborted = 0; stalled = 0; r = 0;
        held_d = 0; held_r = 0; held_c = 0;
        img = layer_v[i]; ker = kern_v[i];

        @(negedge clk); start_v[i] = 1'b1;
        @(negedge clk); start_v[i] = 1'b0;
        check_eq("busy_in_load", 32'(busy_v[i]), 1);
        check_eq("valid_in_load", 32'(valid_v[i]), 0);
        @(negedge clk);
        check_eq("valid_first_run", 32'(valid_v[i]), 0);
        // inputs are free to change once captured
        layer_v[i] = rand_vec();
        kern_v[i]  = {$urandom, $urandom};
        @(negedge clk);
        check_eq("first_valid_latency", 32'(valid_v[i]), 1);

        while (!fin && !aborted && cyc < 30000) begin
            if (done_v[i]) begin
                dones++;
                check_eq("done_after_last", acc, n);
                check_eq("busy_at_done", 32'(busy_v[i]), 0);
                fin = 1;
            end else if (abort_at > 0 && acc == abort_at) begin
                rst = 1'b1;
                #1;
                check_eq("abort_busy", 32'(busy_v[i]), 0);
                check_eq("abort_valid", 32'(valid_v[i]), 0);
                check_eq("abort_data", 32'(data_v[i]), 0);
                @(negedge clk);
                rst = 1'b0;
                ready_v[i] = 1'b1;
                repeat (6) begin
                    @(negedge clk);
                    if (done_v[i]) dones++;
                end
                check_eq("abort_idle_valid", 32'(valid_v[i]), 0);
                aborted = 1;
            end else begin
                case (rmode)
                    0: r = 1'b1;
                    1: r = (rc % 4 == 0) || (rc % 4 == 3);
                    default: r = 1'($urandom_range(0, 1));
                endcase
                rc++;
                ready_v[i] = r;
                start_v[i] = poke_start && (acc >= n / 2) && (acc < n / 2 + 3);
                if (stalled) begin
                    check_eq("stall_valid", 32'(valid_v[i]), 1);
                    check_eq("stall_data", 32'(data_v[i]), 32'(held_d));
                    check_eq("stall_row", 32'(row_v[i]), 32'(held_r));
                    check_eq("stall_col", 32'(col_v[i]), 32'(held_c));
                end
                if (valid_v[i]) begin
                    if (r) begin
                        check_eq("row", 32'(row_v[i]), acc / ow);
                        check_eq("col", 32'(col_v[i]), acc % ow);
                        check_eq("data", 32'(data_v[i]),
                                 ref_word(img, ker, iw, kh, kw, nch, sm, th, acc / ow, acc % ow));
                        acc++;
                    end
                    stalled = !r;
                    held_d = data_v[i]; held_r = row_v[i]; held_c = col_v[i];
                end else begin
                    stalled = 0;
                end
                @(negedge clk);
                cyc++;
            end
        end

        ready_v[i] = 1'b0;
        start_v[i] = 1'b0;
        if (aborted) begin
            check_eq("abort_no_done", dones, 0);
        end else begin
            check_eq("result_count", acc, n);
            repeat (3) begin
                @(negedge clk);
                if (done_v[i]) dones++;
            end
            check_eq("done_once", dones, 1);
            check_eq("busy_idle", 32'(busy_v[i]), 0);
        end
    endtask

    // ---------------- main sequence ----------------
    initial begin
        total = 0;
        bad = 0;
        rst = 1'b1;
        for (int i = 0; i < 4; i++) begin
            start_v[i] = 1'b0;
            ready_v[i] = 1'b0;
            layer_v[i] = '0;
            kern_v[i]  = '0;
        end
        repeat (3) @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            check_eq("rst_busy", 32'(busy_v[i]), 0);
            check_eq("rst_valid", 32'(valid_v[i]), 0);
            check_eq("rst_done", 32'(done_v[i]), 0);
            check_eq("rst_data", 32'(data_v[i]), 0);
            check_eq("rst_row", 32'(row_v[i]), 0);
            check_eq("rst_col", 32'(col_v[i]), 0);
        end
        rst = 1'b0;
        @(negedge clk);

        // all-ones map and kernel: every word is 9
        layer_v[0] = '1; kern_v[0] = '1;
        run_pass(0, 28, 28, 3, 3, 1, 0, 5, 0, 0, 1'b0);

        // reset at the 100th result, then a full pass after restart
        layer_v[0] = rand_vec(); kern_v[0] = {$urandom, $urandom};
        run_pass(0, 28, 28, 3, 3, 1, 0, 5, 0, 100, 1'b0);
        layer_v[0] = rand_vec(); kern_v[0] = {$urandom, $urandom};
        run_pass(0, 28, 28, 3, 3, 1, 0, 5, 0, 0, 1'b0);

        // random ready with start poked mid-pass; then the 1,0,0,1 ready pattern
        layer_v[0] = rand_vec(); kern_v[0] = {$urandom, $urandom};
        run_pass(0, 28, 28, 3, 3, 1, 0, 5, 2, 0, 1'b1);
        layer_v[0] = rand_vec(); kern_v[0] = {$urandom, $urandom};
        run_pass(0, 28, 28, 3, 3, 1, 0, 5, 1, 0, 1'b0);

        // checkerboard map against a matching and an inverted checkerboard kernel
        layer_v[1] = '0; kern_v[1] = '0;
        for (int r = 0; r < 5; r++)
            for (int c = 0; c < 5; c++)
                layer_v[1][r*5 + c] = 1'((r + c) % 2);
        for (int kr = 0; kr < 3; kr++)
            for (int kc = 0; kc < 3; kc++) begin
                kern_v[1][kr*3 + kc]     = 1'((kr + kc) % 2);
                kern_v[1][9 + kr*3 + kc] = 1'((kr + kc + 1) % 2);
            end
        run_pass(1, 5, 5, 3, 3, 2, 0, 5, 0, 0, 1'b0);
        layer_v[1] = rand_vec(); kern_v[1] = {$urandom, $urandom};
        run_pass(1, 5, 5, 3, 3, 2, 0, 5, 1, 0, 1'b0);

        // sign mode on an all-zero map: 4 matches -> 0, 5 matches -> 1
        layer_v[2] = '0;
        kern_v[2] = 64'({9'b111110000, 9'b111110000});
        run_pass(2, 5, 5, 3, 3, 2, 1, 5, 2, 0, 1'b0);
        kern_v[2] = 64'({9'b111100000, 9'b111100000});
        run_pass(2, 5, 5, 3, 3, 2, 1, 5, 2, 0, 1'b0);
        layer_v[2] = rand_vec(); kern_v[2] = {$urandom, $urandom};
        run_pass(2, 5, 5, 3, 3, 2, 1, 5, 1, 0, 1'b0);

        // single-position case
        for (int k = 0; k < 3; k++) begin
            layer_v[3] = rand_vec(); kern_v[3] = {$urandom, $urandom};
            run_pass(3, 3, 3, 3, 3, 1, 0, 5, 2, 0, 1'b0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
